// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths and the buffered write-entry layout for the register-file write arbiter.
package regfile_write_arbiter_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int ENTRY_W    = REG_ADDR_W + XLEN;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } rf_wr_t;

  // x0 is hardwired to zero, so it is never written and never tracked as pending.
  function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_wb.sv
// DEPTH-entry MDU result buffer (rd + data), head visible combinationally.
// Push is ignored when full, pop is ignored when empty; same-cycle push+pop is supported.
module wb_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_dat_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single register-file write port shared by pipeline writeback (always wins) and buffered MDU results.
// Write port is registered (1 cycle after acceptance); MDU is backpressured via mdu_ready when the buffer is full.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wb_valid,
  input  logic [REG_ADDR_W-1:0]        wb_rd,
  input  logic signed [XLEN-1:0]       wb_data,
  input  logic                         mdu_valid,
  input  logic [REG_ADDR_W-1:0]        mdu_rd,
  input  logic signed [XLEN-1:0]       mdu_data,
  output logic                         mdu_ready,
  input  logic                         issue_valid,
  input  logic [REG_ADDR_W-1:0]        issue_rd,
  input  logic [REG_ADDR_W-1:0]        chk_rs1,
  input  logic [REG_ADDR_W-1:0]        chk_rs2,
  input  logic [REG_ADDR_W-1:0]        chk_rd,
  output logic                         stall,
  output logic                         rf_we,
  output logic [REG_ADDR_W-1:0]        rf_rd,
  output logic signed [XLEN-1:0]       rf_wdata
);

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  rf_wr_t                mdu_entry;
  logic [ENTRY_W-1:0]    head_raw;
  rf_wr_t                head;

  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  assign mdu_entry = '{rd: mdu_rd, data: mdu_data};
  assign head      = rf_wr_t'(head_raw);
  assign mdu_ready = !fifo_full;
  assign fifo_push = mdu_valid && !fifo_full;
  // Results always go through the buffer, even when empty, so the head only drains in wb-idle cycles.
  assign fifo_pop  = !wb_valid && !fifo_empty;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (fifo_push),
    .push_dat_i (mdu_entry),
    .pop_i      (fifo_pop),
    .head_o     (head_raw),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = '0;
    rf_wdata_d = '0;
    if (wb_valid) begin
      rf_we_d    = writes_reg(wb_rd);
      rf_rd_d    = wb_rd;
      rf_wdata_d = wb_data;
    end else if (fifo_pop) begin
      rf_we_d    = writes_reg(head.rd);
      rf_rd_d    = head.rd;
      rf_wdata_d = head.data;
    end
  end

  // Clear before set so a new issue to the register being retired stays pending.
  always_comb begin
    pending_d = pending_q;
    if (fifo_pop) begin
      pending_d[head.rd] = 1'b0;
    end
    if (issue_valid) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      pending_q  <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      pending_q  <= pending_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign stall    = pending_q[chk_rs1] | pending_q[chk_rs2] | pending_q[chk_rd];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector table, reset corner cases and random traffic against a queue-based reference model.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int DEPTH = 2;

  logic              clk;
  logic              rst_n;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic signed [63:0] wb_data;
  logic              mdu_valid;
  logic [4:0]        mdu_rd;
  logic signed [63:0] mdu_data;
  logic              mdu_ready;
  logic              issue_valid;
  logic [4:0]        issue_rd;
  logic [4:0]        chk_rs1, chk_rs2, chk_rd;
  logic              stall;
  logic              rf_we;
  logic [4:0]        rf_rd;
  logic signed [63:0] rf_wdata;

  regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .stall(stall), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nvec = 0;
  int nmis = 0;

  // Reference model: ordered queue of buffered results plus a pending flag per register.
  rf_wr_t mq[$];
  bit     pend [32];
  bit     exp_we;
  logic [4:0]  exp_rd;
  logic [63:0] exp_data;

  typedef struct {
    logic wv; logic [4:0] wrd; logic [63:0] wd;
    logic mv; logic [4:0] mrd; logic [63:0] md;
    logic iv; logic [4:0] ird;
    logic [4:0] c1; logic [4:0] c2; logic [4:0] c3;
    logic we; logic [4:0] rd; logic [63:0] d;
    logic st; logic rdy;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int wv, input int wrd, input logic [63:0] wd,
                     input int mv, input int mrd, input logic [63:0] md,
                     input int iv, input int ird,
                     input int c1, input int c2, input int c3,
                     input int we, input int rd, input logic [63:0] d,
                     input int st, input int rdy);
    vec_t v;
    v.wv = 1'(wv); v.wrd = 5'(wrd); v.wd = wd;
    v.mv = 1'(mv); v.mrd = 5'(mrd); v.md = md;
    v.iv = 1'(iv); v.ird = 5'(ird);
    v.c1 = 5'(c1); v.c2 = 5'(c2); v.c3 = 5'(c3);
    v.we = 1'(we); v.rd = 5'(rd); v.d = d;
    v.st = 1'(st); v.rdy = 1'(rdy);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    exp_we = 1'b0;
    exp_rd = '0;
    exp_data = '0;
  endtask

  task automatic model_edge();
    rf_wr_t h;
    bit room;
    if (!rst_n) return;
    room = (mq.size() < DEPTH);
    if (wb_valid) begin
      exp_we = (wb_rd != 0); exp_rd = wb_rd; exp_data = wb_data;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      exp_we = (h.rd != 0); exp_rd = h.rd; exp_data = h.data;
      pend[h.rd] = 1'b0;
    end else begin
      exp_we = 1'b0;
    end
    if (mdu_valid && room) begin
      h.rd = mdu_rd; h.data = mdu_data;
      mq.push_back(h);
    end
    if (issue_valid && issue_rd != 0) pend[issue_rd] = 1'b1;
  endtask

  task automatic model_check();
    bit es;
    es = pend[chk_rs1] | pend[chk_rs2] | pend[chk_rd];
    chk("model.rf_we", 64'(rf_we), 64'(exp_we));
    if (exp_we) begin
      chk("model.rf_rd", 64'(rf_rd), 64'(exp_rd));
      chk("model.rf_wdata", 64'(rf_wdata), exp_data);
    end
    chk("model.stall", 64'(stall), 64'(es));
    chk("model.mdu_ready", 64'(mdu_ready), 64'(mq.size() < DEPTH));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    issue_valid = 0; issue_rd = 0;
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
  endtask

  // Called just after a falling edge: pulse reset between edges and check outputs clear at once.
  task automatic mid_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst.rf_we", 64'(rf_we), 64'd0);
    chk("rst.rf_rd", 64'(rf_rd), 64'd0);
    chk("rst.rf_wdata", 64'(rf_wdata), 64'd0);
    chk("rst.stall", 64'(stall), 64'd0);
    chk("rst.mdu_ready", 64'(mdu_ready), 64'd1);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_rs1 = 5'd7; chk_rs2 = 5'd9; chk_rd = 5'd3;
    #1;
    chk("reset.rf_we", 64'(rf_we), 64'd0);
    chk("reset.rf_rd", 64'(rf_rd), 64'd0);
    chk("reset.rf_wdata", 64'(rf_wdata), 64'd0);
    chk("reset.stall", 64'(stall), 64'd0);
    chk("reset.mdu_ready", 64'(mdu_ready), 64'd1);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    //   wb: v rd data | mdu: v rd data | issue v rd | chk rs1 rs2 rd | exp: we rd data | stall rdy
    add(1,5,64'h1234, 0,0,64'h0, 0,0, 0,0,0,  1,5,64'h1234, 0,1);
    add(0,0,64'h0, 0,0,64'h0, 1,7, 0,0,0,      0,0,64'h0, 0,1);
    add(0,0,64'h0, 0,0,64'h0, 0,0, 7,0,0,      0,0,64'h0, 1,1);
    add(0,0,64'h0, 1,7,64'hFFFF_FFFF_FFFF_FFFD, 0,0, 7,0,0, 0,0,64'h0, 1,1);
    add(0,0,64'h0, 0,0,64'h0, 0,0, 7,0,0,      1,7,64'hFFFF_FFFF_FFFF_FFFD, 0,1);
    add(1,1,64'h11, 1,3,64'h33, 0,0, 0,0,0,    1,1,64'h11, 0,1);
    add(1,2,64'h22, 1,4,64'h44, 0,0, 0,0,0,    1,2,64'h22, 0,0);
    add(1,5,64'h55, 1,6,64'h66, 0,0, 0,0,0,    1,5,64'h55, 0,0);
    add(1,6,64'h66, 0,0,64'h0, 0,0, 0,0,0,     1,6,64'h66, 0,0);
    add(0,0,64'h0, 0,0,64'h0, 0,0, 0,0,0,      1,3,64'h33, 0,1);
    add(0,0,64'h0, 0,0,64'h0, 0,0, 0,0,0,      1,4,64'h44, 0,1);
    add(0,0,64'h0, 0,0,64'h0, 0,0, 0,0,0,      0,0,64'h0, 0,1);
    add(0,0,64'h0, 0,0,64'h0, 1,9, 0,0,0,      0,0,64'h0, 0,1);
    add(0,0,64'h0, 1,9,64'h99, 0,0, 0,9,0,     0,0,64'h0, 1,1);
    add(0,0,64'h0, 0,0,64'h0, 1,9, 0,9,0,      1,9,64'h99, 1,1);
    add(0,0,64'h0, 0,0,64'h0, 0,0, 0,9,0,      0,0,64'h0, 1,1);
    add(0,0,64'h0, 1,9,64'h1, 0,0, 0,9,0,      0,0,64'h0, 1,1);
    add(0,0,64'h0, 0,0,64'h0, 0,0, 0,9,0,      1,9,64'h1, 0,1);
    add(0,0,64'h0, 1,0,64'h5, 1,0, 0,0,0,      0,0,64'h0, 0,1);
    add(0,0,64'h0, 0,0,64'h0, 0,0, 0,0,0,      0,0,64'h0, 0,1);
    add(1,0,64'h7, 0,0,64'h0, 0,0, 0,0,0,      0,0,64'h0, 0,1);
    add(0,0,64'h0, 0,0,64'h0, 1,12, 0,0,0,     0,0,64'h0, 0,1);
    add(0,0,64'h0, 0,0,64'h0, 0,0, 0,0,12,     0,0,64'h0, 1,1);
    add(0,0,64'h0, 1,12,64'hC, 0,0, 0,0,12,    0,0,64'h0, 1,1);
    add(0,0,64'h0, 0,0,64'h0, 0,0, 0,0,12,     1,12,64'hC, 0,1);

    foreach (tbl[i]) begin
      wb_valid = tbl[i].wv; wb_rd = tbl[i].wrd; wb_data = tbl[i].wd;
      mdu_valid = tbl[i].mv; mdu_rd = tbl[i].mrd; mdu_data = tbl[i].md;
      issue_valid = tbl[i].iv; issue_rd = tbl[i].ird;
      chk_rs1 = tbl[i].c1; chk_rs2 = tbl[i].c2; chk_rd = tbl[i].c3;
      step();
      chk($sformatf("row%0d.rf_we", i), 64'(rf_we), 64'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("row%0d.rf_rd", i), 64'(rf_rd), 64'(tbl[i].rd));
        chk($sformatf("row%0d.rf_wdata", i), 64'(rf_wdata), tbl[i].d);
      end
      chk($sformatf("row%0d.stall", i), 64'(stall), 64'(tbl[i].st));
      chk($sformatf("row%0d.mdu_ready", i), 64'(mdu_ready), 64'(tbl[i].rdy));
    end

    // Fill the buffer behind writeback, then reset with two results still queued.
    idle_inputs();
    issue_valid = 1; issue_rd = 5'd3;
    wb_valid = 1; wb_rd = 5'd1; wb_data = 64'hA1;
    mdu_valid = 1; mdu_rd = 5'd3; mdu_data = 64'h33;
    step();
    issue_rd = 5'd4;
    wb_rd = 5'd2; wb_data = 64'hA2;
    mdu_rd = 5'd4; mdu_data = 64'h44;
    chk_rs1 = 5'd3;
    step();
    chk("full.mdu_ready", 64'(mdu_ready), 64'd0);
    chk("full.rf_we", 64'(rf_we), 64'd1);
    chk("full.stall", 64'(stall), 64'd1);
    mid_reset();
    for (int k = 0; k < 4; k++) begin
      chk_rs1 = 5'd3; chk_rs2 = 5'd4;
      step();
      chk($sformatf("postrst%0d.rf_we", k), 64'(rf_we), 64'd0);
      chk($sformatf("postrst%0d.stall", k), 64'(stall), 64'd0);
      chk($sformatf("postrst%0d.mdu_ready", k), 64'(mdu_ready), 64'd1);
    end

    for (int i = 0; i < 3000; i++) begin
      int ph;
      if (i == 1000 || i == 2000) mid_reset();
      ph = (i / 250) % 3;
      if (ph == 0) wb_valid = ($urandom_range(0, 3) != 0);
      else if (ph == 1) wb_valid = ($urandom_range(0, 3) == 0);
      else wb_valid = ($urandom_range(0, 1) == 1);
      wb_rd = 5'($urandom);
      wb_data = {$urandom, $urandom};
      mdu_valid = ($urandom_range(0, 1) == 1);
      mdu_rd = 5'($urandom_range(0, 7));
      mdu_data = {$urandom, $urandom};
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd = 5'($urandom_range(0, 7));
      chk_rs1 = 5'($urandom_range(0, 7));
      chk_rs2 = 5'($urandom_range(0, 7));
      chk_rd = 5'($urandom_range(0, 7));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
